// File: rtl/display_pkg.sv
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared widths, display mode encodings and controller state type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int CODE_W  = 5;
    localparam int DATA_W  = 11;
    localparam int TIMER_W = 8;

    localparam logic [1:0] MODE_MSG      = 2'b00;
    localparam logic [1:0] MODE_DATA     = 2'b01;
    localparam logic [1:0] MODE_MSG_DATA = 2'b10;
    localparam logic [1:0] MODE_TIME     = 2'b11;

    typedef enum logic [1:0] {
        S_TIME = 2'd0,
        S_DATA = 2'd1,
        S_MSG  = 2'd2
    } state_t;

    function automatic logic [1:0] msg_mode(input logic with_data);
        return with_data ? MODE_MSG_DATA : MODE_MSG;
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_ctrl_if.sv
// ============================================================================
// Module   : display_ctrl_if
// Purpose  : Request/status bundle between a display client and display_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface display_ctrl_if;
    import display_pkg::*;

    logic                tick;
    logic                msg_req;
    logic [CODE_W-1:0]   msg_code;
    logic                msg_with_data;
    logic [DATA_W-1:0]   msg_data;
    logic                msg_clr;
    logic                data_en;
    logic [DATA_W-1:0]   data_in;
    logic [1:0]          mode;
    logic [CODE_W-1:0]   message_code;
    logic [DATA_W-1:0]   data;
    logic                msg_ack;
    logic                busy;

    modport master (
        output tick, msg_req, msg_code, msg_with_data, msg_data, msg_clr, data_en, data_in,
        input  mode, message_code, data, msg_ack, busy
    );

    modport slave (
        input  tick, msg_req, msg_code, msg_with_data, msg_data, msg_clr, data_en, data_in,
        output mode, message_code, data, msg_ack, busy
    );

endinterface

`default_nettype wire

// File: rtl/display_ctrl_hold_timer.sv
// ============================================================================
// Module   : hold_timer
// Purpose  : Loadable down-counter that flags expiry on a tick seen at count 1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hold_timer
    import display_pkg::*;
#(
    parameter logic [TIMER_W-1:0] LOAD_VAL = 8'd3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load_i,
    input  wire logic clear_i,
    input  wire logic tick_i,
    output logic      expire_o
);

    logic [TIMER_W-1:0] count_q;

    assign expire_o = tick_i && (count_q == TIMER_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= LOAD_VAL;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (tick_i && (count_q != '0)) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_ctrl.sv
// ============================================================================
// Module   : display_ctrl
// Purpose  : Chooses between clock view, data view and timed transient messages.
// Revision : 1.0
// ============================================================================
`default_nettype none

module display_ctrl
    import display_pkg::*;
#(
    parameter int                HOLD_TICKS    = 3,
    parameter logic [CODE_W-1:0] TIME_MSG_CODE = 5'd0,
    parameter logic [CODE_W-1:0] DATA_MSG_CODE = 5'd1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    display_ctrl_if.slave bus
);

    localparam logic [TIMER_W-1:0] c_hold_load = TIMER_W'(HOLD_TICKS);

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   lat_code_q, lat_code_d;
    logic                lat_wd_q, lat_wd_d;
    logic [DATA_W-1:0]   lat_data_q, lat_data_d;
    logic [1:0]          mode_q, mode_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;

    logic w_load, w_leave, w_tick_msg, w_expire;

    assign w_tick_msg = bus.tick && (state_q == S_MSG);

    hold_timer #(
        .LOAD_VAL (c_hold_load)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_load),
        .clear_i  (w_leave),
        .tick_i   (w_tick_msg),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d    = state_q;
        lat_code_d = lat_code_q;
        lat_wd_d   = lat_wd_q;
        lat_data_d = lat_data_q;
        w_load     = 1'b0;
        w_leave    = 1'b0;

        // A new request overrides clear, expiry and data_en in every state.
        if (bus.msg_req) begin
            state_d    = S_MSG;
            w_load     = 1'b1;
            lat_code_d = bus.msg_code;
            lat_wd_d   = bus.msg_with_data;
            lat_data_d = bus.msg_data;
        end else begin
            case (state_q)
                S_MSG: begin
                    if (bus.msg_clr || w_expire) begin
                        w_leave = 1'b1;
                        state_d = bus.data_en ? S_DATA : S_TIME;
                    end
                end
                S_TIME:  if (bus.data_en)  state_d = S_DATA;
                S_DATA:  if (!bus.data_en) state_d = S_TIME;
                default: state_d = S_TIME;
            endcase
        end

        // Outputs are decoded from the next state so they register with it.
        case (state_d)
            S_MSG: begin
                mode_d = msg_mode(lat_wd_d);
                code_d = lat_code_d;
                data_d = lat_data_d;
                busy_d = 1'b1;
            end
            S_DATA: begin
                mode_d = MODE_DATA;
                code_d = DATA_MSG_CODE;
                data_d = bus.data_in;
                busy_d = 1'b0;
            end
            default: begin
                mode_d = MODE_TIME;
                code_d = TIME_MSG_CODE;
                data_d = '0;
                busy_d = 1'b0;
            end
        endcase
        ack_d = bus.msg_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_TIME;
            lat_code_q <= '0;
            lat_wd_q   <= 1'b0;
            lat_data_q <= '0;
            mode_q     <= MODE_TIME;
            code_q     <= TIME_MSG_CODE;
            data_q     <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_code_q <= lat_code_d;
            lat_wd_q   <= lat_wd_d;
            lat_data_q <= lat_data_d;
            mode_q     <= mode_d;
            code_q     <= code_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.mode         = mode_q;
    assign bus.message_code = code_q;
    assign bus.data         = data_q;
    assign bus.msg_ack      = ack_q;
    assign bus.busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_display_ctrl.sv
// ============================================================================
// Module   : tb_display_ctrl
// Purpose  : Directed self-checking bench for display_ctrl with a view model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_display_ctrl;

    localparam int HOLD = 3;

    logic clk = 1'b0;
    logic rst;

    display_ctrl_if bus ();

    display_ctrl #(
        .HOLD_TICKS    (HOLD),
        .TIME_MSG_CODE (5'd0),
        .DATA_MSG_CODE (5'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int acks  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: "is a message on screen, how many ticks remain, is data wanted".
    bit m_valid = 0, m_on = 0, m_dv = 0, m_wd = 0, m_ack = 0;
    int m_left = 0, m_code = 0, m_dat = 0, m_live = 0;
    int e_mode, e_code, e_data, e_busy;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_on = 0; m_dv = 0; m_wd = 0; m_ack = 0;
            m_left = 0; m_code = 0; m_dat = 0;
        end else begin
            m_ack  = bus.msg_req;
            m_live = int'(bus.data_in);
            if (bus.msg_req) begin
                m_on   = 1;
                m_left = HOLD;
                m_code = int'(bus.msg_code);
                m_wd   = bus.msg_with_data;
                m_dat  = int'(bus.msg_data);
            end else if (m_on) begin
                if (bus.msg_clr) m_on = 0;
                else if (bus.tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_on = 0;
                end
                if (!m_on) m_dv = bus.data_en;
            end else begin
                m_dv = bus.data_en;
            end
        end
        #1;
        if (m_valid) begin
            if (m_on) begin
                e_mode = m_wd ? 2 : 0; e_code = m_code; e_data = m_dat; e_busy = 1;
            end else if (m_dv) begin
                e_mode = 1; e_code = 1; e_data = m_live; e_busy = 0;
            end else begin
                e_mode = 3; e_code = 0; e_data = 0; e_busy = 0;
            end
            chk("mdl_mode", 32'(bus.mode), 32'(e_mode));
            chk("mdl_code", 32'(bus.message_code), 32'(e_code));
            chk("mdl_data", 32'(bus.data), 32'(e_data));
            chk("mdl_busy", 32'(bus.busy), 32'(e_busy));
            chk("mdl_ack", 32'(bus.msg_ack), 32'(m_ack));
            if (bus.msg_ack === 1'b1) acks++;
        end
    end

    task automatic step(input bit r, input bit t, input bit q, input bit c);
        rst         = r;
        bus.tick    = t;
        bus.msg_req = q;
        bus.msg_clr = c;
        @(negedge clk);
    endtask

    task automatic set_msg(input int code, input bit wd, input int d);
        bus.msg_code      = 5'(code);
        bus.msg_with_data = wd;
        bus.msg_data      = 11'(d);
    endtask

    initial begin
        rst = 1'b1;
        bus.tick = 0; bus.msg_req = 0; bus.msg_clr = 0;
        bus.data_en = 0; bus.data_in = '0;
        set_msg(0, 0, 0);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_mode", 32'(bus.mode), 3);
        chk("rst_code", 32'(bus.message_code), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ack", 32'(bus.msg_ack), 0);

        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("idle_mode", 32'(bus.mode), 3);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("stray_tick_clr_mode", 32'(bus.mode), 3);

        // Data view follows data_en one edge later.
        bus.data_en = 1; bus.data_in = 11'd250;
        step(0, 0, 0, 0);
        chk("dv_mode", 32'(bus.mode), 1);
        chk("dv_data", 32'(bus.data), 250);
        bus.data_en = 0;
        step(0, 0, 0, 0);
        chk("dv_off_mode", 32'(bus.mode), 3);

        // Message with data held for exactly three ticks.
        set_msg(7, 1, 1024);
        step(0, 0, 1, 0);
        chk("m1_mode", 32'(bus.mode), 2);
        chk("m1_code", 32'(bus.message_code), 7);
        chk("m1_data", 32'(bus.data), 1024);
        chk("m1_ack", 32'(bus.msg_ack), 1);
        step(0, 1, 0, 0);
        chk("m1_ack_pulse", 32'(bus.msg_ack), 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("m1_tick2_mode", 32'(bus.mode), 2);
        step(0, 1, 0, 0);
        chk("m1_expired_mode", 32'(bus.mode), 3);
        chk("m1_expired_busy", 32'(bus.busy), 0);

        // Pre-empting request on the expiring tick restarts the hold.
        bus.data_en = 1; bus.data_in = 11'd77;
        step(0, 0, 0, 0);
        chk("m2_pre_mode", 32'(bus.mode), 1);
        set_msg(5, 0, 3);
        step(0, 0, 1, 0);
        chk("m2_code", 32'(bus.message_code), 5);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        set_msg(9, 0, 4);
        step(0, 1, 1, 0);
        chk("m3_code", 32'(bus.message_code), 9);
        chk("m3_ack", 32'(bus.msg_ack), 1);
        chk("m3_mode", 32'(bus.mode), 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("m3_held_code", 32'(bus.message_code), 9);
        step(0, 1, 0, 0);
        chk("m3_exp_mode", 32'(bus.mode), 1);
        chk("m3_exp_data", 32'(bus.data), 77);
        chk("m3_exp_code", 32'(bus.message_code), 1);

        // Request beats clear in the same cycle; clear alone cancels.
        bus.data_en = 0;
        set_msg(3, 0, 0);
        step(0, 0, 1, 1);
        chk("m4_mode", 32'(bus.mode), 0);
        chk("m4_busy", 32'(bus.busy), 1);
        step(0, 0, 0, 1);
        chk("m4_clr_mode", 32'(bus.mode), 3);

        // Reset mid-message drops a simultaneous request.
        set_msg(12, 1, 500);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        chk("m5_mode", 32'(bus.mode), 2);
        set_msg(20, 1, 9);
        step(1, 1, 1, 0);
        chk("m5_rst_mode", 32'(bus.mode), 3);
        chk("m5_rst_code", 32'(bus.message_code), 0);
        chk("m5_rst_data", 32'(bus.data), 0);
        chk("m5_rst_ack", 32'(bus.msg_ack), 0);
        chk("m5_rst_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("m5_post_tick_mode", 32'(bus.mode), 3);
        end

        chk("ack_count", 32'(acks), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_ctrl.md
DISPLAY_CTRL -- requirements
Module: display_ctrl

Interface
REQ-001 Parameter HOLD_TICKS, default 3, meaning tick periods a transient message stays shown; legal range 1..255.
REQ-002 Parameter TIME_MSG_CODE, default 5'd0, meaning message_code driven while the clock view is shown.
REQ-003 Parameter DATA_MSG_CODE, default 5'd1, meaning message_code driven while the data view is shown.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 tick  input  1  one-cycle timebase strobe for the hold timer.
REQ-007 msg_req  input  1  one-cycle request to show a transient message.
REQ-008 msg_code  input  5  message code, sampled with msg_req.
REQ-009 msg_with_data  input  1  show msg_data beside the message; sampled with msg_req.
REQ-010 msg_data  input  11  value shown with the message; sampled with msg_req.
REQ-011 msg_clr  input  1  cancel the current message immediately.
REQ-012 data_en  input  1  level; persistent data view wanted (e.g. balance).
REQ-013 data_in  input  11  live value for the data view.
REQ-014 mode  output  2  display mode: 00 message, 01 data, 10 message+data, 11 clock.
REQ-015 message_code  output  5  message code to the display.
REQ-016 data  output  11  value to the display.
REQ-017 msg_ack  output  1  one-cycle pulse; message accepted.
REQ-018 busy  output  1  high while a message is shown.

Function
REQ-019 All outputs shall be registered; an input sampled at edge k shall be reflected on the outputs after edge k.
REQ-020 FSM states shall be S_TIME, S_DATA and S_MSG.
REQ-021 S_TIME outputs: mode=11, message_code=TIME_MSG_CODE, data=0, busy=0.
REQ-022 S_DATA outputs: mode=01, message_code=DATA_MSG_CODE, data=data_in (registered every cycle), busy=0.
REQ-023 S_MSG outputs: mode=10 if latched with_data else 00; message_code and data are the latched values; busy=1.
REQ-024 Priority: msg_req > msg_clr > timer expiry > data_en.
REQ-025 msg_req in any state shall latch code, with_data and data, load the timer with HOLD_TICKS, enter S_MSG and pulse msg_ack.
REQ-026 msg_req in S_MSG shall pre-empt the current message and reload the timer; the last request wins.
REQ-027 In S_MSG, each tick shall decrement the timer; a tick seen with timer==1 is expiry.
REQ-028 Expiry or msg_clr shall leave S_MSG for S_DATA if data_en=1, else for S_TIME.
REQ-029 msg_req and expiry in the same cycle: the request wins and the timer reloads to HOLD_TICKS.
REQ-030 msg_req and msg_clr in the same cycle: the request wins.
REQ-031 In S_TIME, data_en=1 shall go to S_DATA; in S_DATA, data_en=0 shall go to S_TIME.
REQ-032 msg_clr outside S_MSG and tick outside S_MSG shall have no effect.
REQ-033 The timer shall be 8 bits and shall never wrap below 1 while in S_MSG.

Reset
REQ-034 rst=1 at an edge shall force S_TIME, mode=11, message_code=TIME_MSG_CODE, data=0, msg_ack=0, busy=0, timer=0, latches=0, whatever operation is in progress.
REQ-035 A msg_req asserted in the same cycle as rst shall be dropped, with no msg_ack.

Structure
REQ-036 Mode encodings (MODE_MSG, MODE_DATA, MODE_MSG_DATA, MODE_TIME) and the state enum shall live in shared package display_pkg.
REQ-037 The hold timer (load, tick decrement, expire flag) shall be sub-module hold_timer; all else stays in display_ctrl.

Verification
REQ-038 Reset, then idle 10 cycles -> mode=11, message_code=0, busy=0, no msg_ack.
REQ-039 data_en=1, data_in=11'd250 -> mode=01 and data=250 after one edge; data_en=0 -> mode=11 after one edge.
REQ-040 msg_req with code=5'd7, with_data=1, msg_data=11'd1024; then 3 ticks -> mode=10 for exactly 3 ticks with one msg_ack pulse, then mode=11.
REQ-041 Message showing, data_en=1, second msg_req with code=5'd9 on the third (expiring) tick -> code 9 shown, timer=3, second msg_ack; after expiry mode=01.
REQ-042 msg_req and msg_clr in the same cycle, then msg_clr alone -> message shown, then cleared to mode=11 on the next edge.
REQ-043 rst asserted mid-message with timer=2 -> all outputs at reset values after the edge; later ticks do not change mode.
